// File: rtl/instr_line_fill_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// instr_line_fill_ctrl_pkg
// Shared definitions for the instruction line-fill controller:
//   - FSM state encoding (IFILL_IDLE .. IFILL_HOLD)
//   - bus / line geometry constants
//   - line-address alignment mask (3 low word-address bits cleared)
// ---------------------------------------------------------------------------
package instr_line_fill_ctrl_pkg;

  localparam int IFILL_BUS_W      = 64;
  localparam int IFILL_BEATS      = 4;
  localparam int IFILL_LINE_W     = IFILL_BUS_W * IFILL_BEATS;
  localparam int IFILL_BEAT_CNT_W = $clog2(IFILL_BEATS);

  // A line holds 8 words, so the low 3 word-address bits select within it.
  localparam int          IFILL_LINE_OFS_BITS = 3;
  localparam logic [31:0] IFILL_LINE_MASK =
    {{(32 - IFILL_LINE_OFS_BITS){1'b1}}, {IFILL_LINE_OFS_BITS{1'b0}}};

  typedef enum logic [2:0] {
    IFILL_IDLE = 3'd0,
    IFILL_REQ  = 3'd1,
    IFILL_BEAT = 3'd2,
    IFILL_DONE = 3'd3,
    IFILL_HOLD = 3'd4
  } ifill_state_e;

endpackage

// File: rtl/instr_line_fill_ctrl_line_assembler.sv
// ---------------------------------------------------------------------------
// ifill_line_assembler
// Beat counter plus line register. Each write inserts one bus beat at the
// slot selected by the counter; load replaces the whole line at once.
// Ports:
//   CLK, RESET     clock, asynchronous active-low reset
//   clear          restart the beat counter at slot 0
//   write          insert beat_data at the current slot, advance counter
//   load           overwrite the line with load_data
//   beat_data      one bus beat
//   load_data      complete replacement line
//   line           registered assembled line
//   done           write of the final beat is happening this cycle
// ---------------------------------------------------------------------------
module ifill_line_assembler #(
  parameter int BUS_W      = 64,
  parameter int BEATS      = 4,
  parameter int BEAT_CNT_W = 2,
  parameter int LINE_W     = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              write,
  input  logic              load,
  input  logic [BUS_W-1:0]  beat_data,
  input  logic [LINE_W-1:0] load_data,
  output logic [LINE_W-1:0] line,
  output logic              done
);

  logic [BEAT_CNT_W-1:0] cnt_r;
  logic [LINE_W-1:0]     line_r;

  // Beat counter and slot insertion into the line register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r  <= '0;
      line_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (load) begin
      line_r <= load_data;
    end else if (write) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_r == BEAT_CNT_W'(k)) begin
          line_r[k*BUS_W +: BUS_W] <= beat_data;
        end
      end
      cnt_r <= cnt_r + {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign line = line_r;
  assign done = write && (cnt_r == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/instr_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// instr_line_fill_ctrl
// Services L1 instruction-cache misses: one bus request per 256-bit line,
// four 64-bit read beats assembled into mem_data, delivered with a one-cycle
// mem_valid pulse. The line is only delivered if the L1 still requests the
// same line when the burst finishes.
// Optional build macro: IFILL_LINE_BUFFER_EN adds a one-entry line buffer
// that answers a repeat request for the last delivered line without bus use.
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   mem_req/mem_address fill request (level) and word address from L1
//   mem_data/mem_valid  assembled line and its delivery pulse
//   bus_req/bus_addr    memory read request and current beat word address
//   bus_gnt             request accepted (single cycle)
//   bus_rdata/bus_rvalid read beat and its qualifier
// ---------------------------------------------------------------------------
module instr_line_fill_ctrl
  import instr_line_fill_ctrl_pkg::*;
#(
  parameter int BUS_W      = IFILL_BUS_W,
  parameter int LINE_W     = IFILL_LINE_W,
  parameter int BEATS      = IFILL_BEATS,
  parameter int BEAT_CNT_W = IFILL_BEAT_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              mem_req,
  input  logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_data,
  output logic              mem_valid,
  output logic              bus_req,
  output logic [31:0]       bus_addr,
  input  logic              bus_gnt,
  input  logic [BUS_W-1:0]  bus_rdata,
  input  logic              bus_rvalid
);

  ifill_state_e      state_r;
  logic [31:0]       line_addr_r;
  logic              bus_req_r;
  logic [31:0]       bus_addr_r;
  logic              mem_valid_r;
  logic              hit_pend_r;

  logic [31:0]       req_line_s;
  logic              req_match_s;
  logic              asm_clear_s;
  logic              asm_write_s;
  logic              asm_load_s;
  logic              asm_done_s;
  logic              buf_hit_s;
  logic [LINE_W-1:0] load_line_s;

  assign req_line_s  = mem_address & IFILL_LINE_MASK;
  assign req_match_s = mem_req && (req_line_s == line_addr_r);

  // Beats are only accepted in BEAT; the counter restarts on the grant.
  assign asm_clear_s = (state_r == IFILL_REQ) && bus_gnt;
  assign asm_write_s = (state_r == IFILL_BEAT) && bus_rvalid;
  assign asm_load_s  = (state_r == IFILL_IDLE) && mem_req && buf_hit_s;

`ifdef IFILL_LINE_BUFFER_EN
  logic              buf_valid_r;
  logic [31:0]       buf_addr_r;
  logic [LINE_W-1:0] buf_line_r;

  // Copy each delivered line; mem_data is final during the mem_valid cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= '0;
      buf_line_r  <= '0;
    end else if ((state_r == IFILL_DONE) && mem_valid_r) begin
      buf_valid_r <= 1'b1;
      buf_addr_r  <= line_addr_r;
      buf_line_r  <= mem_data;
    end
  end

  assign buf_hit_s   = buf_valid_r && (req_line_s == buf_addr_r);
  assign load_line_s = buf_line_r;
`else
  assign buf_hit_s   = 1'b0;
  assign load_line_s = '0;
`endif

  ifill_line_assembler #(
    .BUS_W      (BUS_W),
    .BEATS      (BEATS),
    .BEAT_CNT_W (BEAT_CNT_W),
    .LINE_W     (LINE_W)
  ) u_assembler (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (asm_clear_s),
    .write     (asm_write_s),
    .load      (asm_load_s),
    .beat_data (bus_rdata),
    .load_data (load_line_s),
    .line      (mem_data),
    .done      (asm_done_s)
  );

  // Fill sequencing FSM with registered bus and delivery outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= IFILL_IDLE;
      line_addr_r <= '0;
      bus_req_r   <= 1'b0;
      bus_addr_r  <= '0;
      mem_valid_r <= 1'b0;
      hit_pend_r  <= 1'b0;
    end else begin
      case (state_r)
        IFILL_IDLE: begin
          mem_valid_r <= 1'b0;
          if (mem_req) begin
            line_addr_r <= req_line_s;
            if (buf_hit_s) begin
              // Line already loaded from the buffer; delivery decided in DONE.
              hit_pend_r <= 1'b1;
              state_r    <= IFILL_DONE;
            end else begin
              bus_req_r  <= 1'b1;
              bus_addr_r <= req_line_s;
              state_r    <= IFILL_REQ;
            end
          end
        end
        IFILL_REQ: begin
          if (bus_gnt) begin
            bus_req_r <= 1'b0;
            state_r   <= IFILL_BEAT;
          end
        end
        IFILL_BEAT: begin
          if (bus_rvalid) begin
            bus_addr_r <= bus_addr_r + 32'd2;
          end
          if (asm_done_s) begin
            // Deliver only if the L1 still wants this exact line.
            mem_valid_r <= req_match_s;
            state_r     <= IFILL_DONE;
          end
        end
        IFILL_DONE: begin
          if (hit_pend_r) begin
            hit_pend_r  <= 1'b0;
            mem_valid_r <= req_match_s;
          end else begin
            mem_valid_r <= 1'b0;
            state_r     <= mem_valid_r ? IFILL_HOLD : IFILL_IDLE;
          end
        end
        IFILL_HOLD: begin
          mem_valid_r <= 1'b0;
          if (!req_match_s) begin
            state_r <= IFILL_IDLE;
          end
        end
        default: begin
          state_r     <= IFILL_IDLE;
          bus_req_r   <= 1'b0;
          mem_valid_r <= 1'b0;
          hit_pend_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_addr  = bus_addr_r;
  assign mem_valid = mem_valid_r;

endmodule

// File: tb/tb_instr_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_line_fill_ctrl
// Directed stimulus with a decoupled scoreboard: expected bus addresses and
// lines are queued when a fill is issued; a negedge monitor pops and compares
// whenever bus_req rises or mem_valid pulses.
// ---------------------------------------------------------------------------
module tb_instr_line_fill_ctrl;

  logic         CLK;
  logic         RESET;
  logic         mem_req;
  logic [31:0]  mem_address;
  logic [255:0] mem_data;
  logic         mem_valid;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_gnt;
  logic [63:0]  bus_rdata;
  logic         bus_rvalid;

  int n_cmp;
  int n_err;
  int pulses;
  int exp_pulses;
  logic bus_req_prev;

  logic [255:0] line_q[$];
  logic [31:0]  addr_q[$];

  instr_line_fill_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .mem_req     (mem_req),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_gnt     (bus_gnt),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: outputs are stable at the falling edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      bus_req_prev = 1'b0;
    end else begin
      if (mem_valid) begin
        pulses++;
        if (line_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_mem_valid: got pulse expected none (t=%0t)", $time);
        end else begin
          check("mem_data", mem_data, line_q.pop_front());
        end
      end
      if (bus_req && !bus_req_prev) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_bus_req: got bus_req addr %0h expected none", bus_addr);
        end else begin
          check("bus_addr", {224'd0, bus_addr}, {224'd0, addr_q.pop_front()});
        end
      end
      bus_req_prev = bus_req;
    end
  end

  task automatic send_beat(input logic [63:0] d);
    bus_rvalid = 1'b1;
    bus_rdata  = d;
    @(negedge CLK);
    bus_rvalid = 1'b0;
  endtask

  task automatic send_beats(input logic [255:0] line, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_beat(line[k*64 +: 64]);
      if (k < 3) repeat (gap) @(negedge CLK);
    end
  endtask

  // Called at the negedge where bus_req is already visible.
  task automatic grant(input int delay);
    for (int d = 0; d < delay; d++) begin
      check("bus_req_held", {255'd0, bus_req}, 256'd1);
      @(negedge CLK);
    end
    bus_gnt = 1'b1;
    @(negedge CLK);
    bus_gnt = 1'b0;
    check("bus_req_dropped", {255'd0, bus_req}, 256'd0);
  endtask

  task automatic wait_bus_req(input string name);
    int n;
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (!bus_req) begin
      n_err++;
      $display("FAIL %s: got no bus_req expected bus_req within 20 cycles", name);
    end
  endtask

  task automatic expect_fill(input logic [31:0] a, input logic [255:0] l);
    addr_q.push_back(a);
    line_q.push_back(l);
    exp_pulses++;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l1, l2, l4a, l4b, l5, l6, l7;
    l1  = {64'h1111_0000_0000_0004, 64'h1111_0000_0000_0003,
           64'h1111_0000_0000_0002, 64'h1111_0000_0000_0001};
    l2  = {64'h2222_0000_0000_0004, 64'h2222_0000_0000_0003,
           64'h2222_0000_0000_0002, 64'h2222_0000_0000_0001};
    l4a = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
           64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    l4b = {64'hBBBB_0000_0000_0004, 64'hBBBB_0000_0000_0003,
           64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001};
    l5  = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
           64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
    l6  = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
           64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    l7  = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
           64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    n_cmp = 0; n_err = 0; pulses = 0; exp_pulses = 0;
    bus_req_prev = 1'b0;
    RESET = 1'b0; mem_req = 1'b0; mem_address = 32'h0;
    bus_gnt = 1'b0; bus_rdata = 64'h0; bus_rvalid = 1'b0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_mem_valid", {255'd0, mem_valid}, 256'd0);
    check("rst_mem_data", mem_data, 256'd0);
    check("rst_bus_req", {255'd0, bus_req}, 256'd0);
    check("rst_bus_addr", {224'd0, bus_addr}, 256'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // Minimum-latency fill of 0x100 (low address bits ignored).
    mem_req = 1'b1; mem_address = 32'h0000_0105;
    expect_fill(32'h100, l1);
    @(negedge CLK);
    check("t1_bus_req_n1", {255'd0, bus_req}, 256'd1);
    grant(0);
    send_beats(l1, 0);
    check("t1_mem_valid_n6", {255'd0, mem_valid}, 256'd1);
    check("t1_word0", {224'd0, mem_data[31:0]}, 256'h1);
    check("t1_beat3", {192'd0, mem_data[255:192]}, {192'd0, 64'h1111_0000_0000_0004});
    @(negedge CLK);
    check("t1_pulse_end", {255'd0, mem_valid}, 256'd0);

    // Request held after delivery: no new fill.
    repeat (4) @(negedge CLK);
    check("t3_hold_no_req", {255'd0, bus_req}, 256'd0);

    // Address moves to 0x108: new fill, with delayed grant and gapped beats.
    mem_address = 32'h108;
    expect_fill(32'h108, l2);
    wait_bus_req("t3_req_0x108");
    grant(5);
    send_beats(l2, 2);
    check("t2_mem_valid", {255'd0, mem_valid}, 256'd1);

    // Address changes 0x100 -> 0x200 during beat 2: 0x100 line discarded.
    mem_address = 32'h100;
    addr_q.push_back(32'h100);
    wait_bus_req("t4_req_0x100");
    grant(0);
    send_beat(l4a[63:0]);
    send_beat(l4a[127:64]);
    mem_address = 32'h200;
    expect_fill(32'h200, l4b);
    send_beat(l4a[191:128]);
    send_beat(l4a[255:192]);
    check("t4_suppressed", {255'd0, mem_valid}, 256'd0);
    wait_bus_req("t4_req_0x200");
    grant(0);
    send_beats(l4b, 0);
    check("t4_mem_valid", {255'd0, mem_valid}, 256'd1);

    // Reset after beat 1 of a fill for 0x400.
    mem_address = 32'h400;
    addr_q.push_back(32'h400);
    wait_bus_req("t5_req_0x400");
    grant(0);
    send_beat(l5[63:0]);
    send_beat(l5[127:64]);
    RESET = 1'b0;
    mem_req = 1'b0;
    #1;
    check("t5_rst_mem_valid", {255'd0, mem_valid}, 256'd0);
    check("t5_rst_mem_data", mem_data, 256'd0);
    check("t5_rst_bus_req", {255'd0, bus_req}, 256'd0);
    check("t5_rst_bus_addr", {224'd0, bus_addr}, 256'd0);
    @(negedge CLK);
    send_beat(l5[191:128]);
    RESET = 1'b1;
    send_beat(l5[255:192]);
    send_beat(l5[255:192]);
    check("t5_late_beats_ignored", mem_data, 256'd0);
    check("t5_idle_bus_req", {255'd0, bus_req}, 256'd0);

    // Clean fill of 0x100 after reset release.
    mem_req = 1'b1; mem_address = 32'h100;
    expect_fill(32'h100, l6);
    wait_bus_req("t5_req_clean");
    grant(0);
    send_beats(l6, 1);
    check("t5_clean_valid", {255'd0, mem_valid}, 256'd1);
    mem_req = 1'b0;
    repeat (3) @(negedge CLK);

    // Re-request of the last delivered line.
`ifdef IFILL_LINE_BUFFER_EN
    mem_req = 1'b1;
    line_q.push_back(l6);
    exp_pulses++;
    @(negedge CLK);
    check("t6_n1_no_valid", {255'd0, mem_valid}, 256'd0);
    @(negedge CLK);
    check("t6_n2_valid", {255'd0, mem_valid}, 256'd1);
    check("t6_no_bus_req", {255'd0, bus_req}, 256'd0);
`else
    mem_req = 1'b1;
    expect_fill(32'h100, l7);
    wait_bus_req("t6_req_refetch");
    grant(0);
    send_beats(l7, 0);
    check("t6_refetch_valid", {255'd0, mem_valid}, 256'd1);
`endif
    mem_req = 1'b0;
    repeat (4) @(negedge CLK);

    check("sb_lines_drained", {224'd0, 32'(line_q.size())}, 256'd0);
    check("sb_addrs_drained", {224'd0, 32'(addr_q.size())}, 256'd0);
    check("pulse_count", {224'd0, 32'(pulses)}, {224'd0, 32'(exp_pulses)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
